// File: rtl/kbd_pkg.sv
// kbd_pkg: PS/2 Set-2 scancode constants and the scancode-to-ASCII decode used as ROM contents.
package kbd_pkg;
  localparam logic [7:0] ASCII_NONE = 8'h00;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_I = 8'h43;
  localparam logic [7:0] SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;
  localparam logic [7:0] SC_L = 8'h4B;
  localparam logic [7:0] SC_M = 8'h3A;
  localparam logic [7:0] SC_N = 8'h31;
  localparam logic [7:0] SC_O = 8'h44;
  localparam logic [7:0] SC_P = 8'h4D;
  localparam logic [7:0] SC_Q = 8'h15;
  localparam logic [7:0] SC_R = 8'h2D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_T = 8'h2C;
  localparam logic [7:0] SC_U = 8'h3C;
  localparam logic [7:0] SC_V = 8'h2A;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_X = 8'h22;
  localparam logic [7:0] SC_Y = 8'h35;
  localparam logic [7:0] SC_Z = 8'h1A;
  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;
  localparam logic [7:0] SC_GRAVE = 8'h0E;
  localparam logic [7:0] SC_MINUS = 8'h4E;
  localparam logic [7:0] SC_EQUAL = 8'h55;
  localparam logic [7:0] SC_LBRACK = 8'h54;
  localparam logic [7:0] SC_RBRACK = 8'h5B;
  localparam logic [7:0] SC_BSLASH = 8'h5D;
  localparam logic [7:0] SC_SEMI = 8'h4C;
  localparam logic [7:0] SC_QUOTE = 8'h52;
  localparam logic [7:0] SC_COMMA = 8'h41;
  localparam logic [7:0] SC_PERIOD = 8'h49;
  localparam logic [7:0] SC_SLASH = 8'h4A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP = 8'h66;
  localparam logic [7:0] SC_TAB = 8'h0D;
  localparam logic [7:0] SC_ESC = 8'h76;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL = 8'h14;
  localparam logic [7:0] SC_CAPS = 8'h58;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;

  function automatic logic [7:0] alpha(input logic up, input logic [7:0] ofs);
    return (up ? 8'h41 : 8'h61) + ofs;
  endfunction

  function automatic logic [7:0] pick(input logic sel, input logic [7:0] lo, input logic [7:0] hi);
    return sel ? hi : lo;
  endfunction

  // Letters follow caps XOR shift; digits and punctuation follow shift only.
  function automatic logic [7:0] sc_decode(input logic caps, input logic shift, input logic [7:0] key);
    logic up;
    logic [7:0] r;
    up = caps ^ shift;
    r = ASCII_NONE;
    case (key)
      SC_A: r = alpha(up, 8'd0);
      SC_B: r = alpha(up, 8'd1);
      SC_C: r = alpha(up, 8'd2);
      SC_D: r = alpha(up, 8'd3);
      SC_E: r = alpha(up, 8'd4);
      SC_F: r = alpha(up, 8'd5);
      SC_G: r = alpha(up, 8'd6);
      SC_H: r = alpha(up, 8'd7);
      SC_I: r = alpha(up, 8'd8);
      SC_J: r = alpha(up, 8'd9);
      SC_K: r = alpha(up, 8'd10);
      SC_L: r = alpha(up, 8'd11);
      SC_M: r = alpha(up, 8'd12);
      SC_N: r = alpha(up, 8'd13);
      SC_O: r = alpha(up, 8'd14);
      SC_P: r = alpha(up, 8'd15);
      SC_Q: r = alpha(up, 8'd16);
      SC_R: r = alpha(up, 8'd17);
      SC_S: r = alpha(up, 8'd18);
      SC_T: r = alpha(up, 8'd19);
      SC_U: r = alpha(up, 8'd20);
      SC_V: r = alpha(up, 8'd21);
      SC_W: r = alpha(up, 8'd22);
      SC_X: r = alpha(up, 8'd23);
      SC_Y: r = alpha(up, 8'd24);
      SC_Z: r = alpha(up, 8'd25);
      SC_0: r = pick(shift, 8'h30, 8'h29);
      SC_1: r = pick(shift, 8'h31, 8'h21);
      SC_2: r = pick(shift, 8'h32, 8'h40);
      SC_3: r = pick(shift, 8'h33, 8'h23);
      SC_4: r = pick(shift, 8'h34, 8'h24);
      SC_5: r = pick(shift, 8'h35, 8'h25);
      SC_6: r = pick(shift, 8'h36, 8'h5E);
      SC_7: r = pick(shift, 8'h37, 8'h26);
      SC_8: r = pick(shift, 8'h38, 8'h2A);
      SC_9: r = pick(shift, 8'h39, 8'h28);
      SC_GRAVE: r = pick(shift, 8'h60, 8'h7E);
      SC_MINUS: r = pick(shift, 8'h2D, 8'h5F);
      SC_EQUAL: r = pick(shift, 8'h3D, 8'h2B);
      SC_LBRACK: r = pick(shift, 8'h5B, 8'h7B);
      SC_RBRACK: r = pick(shift, 8'h5D, 8'h7D);
      SC_BSLASH: r = pick(shift, 8'h5C, 8'h7C);
      SC_SEMI: r = pick(shift, 8'h3B, 8'h3A);
      SC_QUOTE: r = pick(shift, 8'h27, 8'h22);
      SC_COMMA: r = pick(shift, 8'h2C, 8'h3C);
      SC_PERIOD: r = pick(shift, 8'h2E, 8'h3E);
      SC_SLASH: r = pick(shift, 8'h2F, 8'h3F);
      SC_SPACE: r = 8'h20;
      SC_ENTER: r = 8'h0D;
      SC_BKSP: r = 8'h08;
      SC_TAB: r = 8'h09;
      SC_ESC: r = 8'h1B;
      default: r = ASCII_NONE;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/scancode_ram.sv
// scancode_ram: registered 1024x8 lookup of {caps, shift, cur_key} to ASCII, one-cycle latency.
module scancode_ram
  import kbd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] cur_key,
  input  logic       caps,
  input  logic       shift,
  output logic [7:0] ascii_key
);
  logic [7:0] ascii_d, ascii_q;
  always_comb ascii_d = sc_decode(caps, shift, cur_key);
  always_ff @(posedge clk) begin
    if (clr) ascii_q <= ASCII_NONE;
    else ascii_q <= ascii_d;
  end
  assign ascii_key = ascii_q;
endmodule

// File: tb/tb_scancode_ram.sv
// tb_scancode_ram: table-driven vectors plus hand sequences for latency and unmapped codes.
module tb_scancode_ram;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [7:0] cur_key = 8'h00;
  logic caps = 1'b0;
  logic shift = 1'b0;
  logic [7:0] ascii_key;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic       c;
    logic [7:0] k;
    logic       cp;
    logic       sh;
    logic [7:0] e;
    string      n;
  } vec_t;
  vec_t vecs[$];

  scancode_ram dut (
    .clk(clk), .clr(clr), .cur_key(cur_key), .caps(caps), .shift(shift), .ascii_key(ascii_key)
  );

  always #5 clk = ~clk;

  function automatic void add(logic c, logic [7:0] k, logic cp, logic sh, logic [7:0] e, string n);
    vecs.push_back('{c, k, cp, sh, e, n});
  endfunction

  task automatic check(string n, logic [7:0] e);
    total++;
    if (ascii_key !== e) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", n, ascii_key, e);
    end
  endtask

  task automatic step(logic c, logic [7:0] k, logic cp, logic sh);
    clr = c; cur_key = k; caps = cp; shift = sh;
    @(posedge clk);
    #1;
  endtask

  initial begin
    add(1, 8'h1C, 0, 0, 8'h00, "reset");
    add(0, 8'h1C, 0, 0, 8'h61, "release_a");
    add(0, 8'h1C, 0, 1, 8'h41, "a_shift");
    add(0, 8'h1C, 1, 0, 8'h41, "a_caps");
    add(0, 8'h1C, 1, 1, 8'h61, "a_caps_shift");
    add(0, 8'h1C, 1, 1, 8'h61, "a_hold");
    add(0, 8'h32, 0, 0, 8'h62, "b");
    add(0, 8'h1A, 0, 0, 8'h7A, "z");
    add(0, 8'h1A, 1, 0, 8'h5A, "Z_caps");
    add(0, 8'h15, 0, 0, 8'h71, "q");
    add(0, 8'h4D, 0, 1, 8'h50, "P_shift");
    add(0, 8'h16, 0, 0, 8'h31, "1");
    add(0, 8'h16, 0, 1, 8'h21, "1_shift");
    add(0, 8'h16, 1, 0, 8'h31, "1_caps");
    add(0, 8'h45, 0, 1, 8'h29, "0_shift");
    add(0, 8'h46, 0, 1, 8'h28, "9_shift");
    add(0, 8'h3E, 1, 1, 8'h2A, "8_caps_shift");
    add(0, 8'h1E, 0, 1, 8'h40, "2_shift");
    add(0, 8'h36, 0, 1, 8'h5E, "6_shift");
    add(0, 8'h4A, 0, 1, 8'h3F, "slash_shift");
    add(0, 8'h4A, 1, 0, 8'h2F, "slash_caps");
    add(0, 8'h0E, 0, 1, 8'h7E, "tilde");
    add(0, 8'h0E, 0, 0, 8'h60, "grave");
    add(0, 8'h4E, 0, 1, 8'h5F, "underscore");
    add(0, 8'h55, 0, 0, 8'h3D, "equal");
    add(0, 8'h54, 0, 1, 8'h7B, "lbrace");
    add(0, 8'h5B, 0, 0, 8'h5D, "rbracket");
    add(0, 8'h5D, 1, 1, 8'h7C, "pipe");
    add(0, 8'h52, 0, 1, 8'h22, "dquote");
    add(0, 8'h4C, 0, 0, 8'h3B, "semicolon");
    add(0, 8'h41, 0, 1, 8'h3C, "lt");
    add(0, 8'h49, 0, 0, 8'h2E, "period");
    add(0, 8'h29, 0, 0, 8'h20, "space");
    add(0, 8'h5A, 1, 1, 8'h0D, "enter");
    add(0, 8'h66, 0, 1, 8'h08, "bksp");
    add(0, 8'h0D, 1, 0, 8'h09, "tab");
    add(0, 8'h76, 0, 0, 8'h1B, "esc");
    add(0, 8'h33, 0, 0, 8'h68, "stream_h");
    add(0, 8'h24, 0, 0, 8'h65, "stream_e");
    add(0, 8'h4B, 0, 0, 8'h6C, "stream_l1");
    add(0, 8'h4B, 0, 0, 8'h6C, "stream_l2");
    add(0, 8'h44, 0, 0, 8'h6F, "stream_o");
    add(0, 8'h33, 0, 0, 8'h68, "mid_h");
    add(1, 8'h24, 0, 0, 8'h00, "mid_reset");
    add(0, 8'h4B, 0, 0, 8'h6C, "mid_l");
    add(0, 8'h44, 0, 0, 8'h6F, "mid_o");
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].c, vecs[i].k, vecs[i].cp, vecs[i].sh);
      check(vecs[i].n, vecs[i].e);
    end
    step(0, 8'h1C, 0, 0);
    check("lat_a", 8'h61);
    cur_key = 8'h32;
    #2;
    check("lat_hold_before_edge", 8'h61);
    @(posedge clk);
    #1;
    check("lat_b", 8'h62);
    shift = 1'b1;
    @(posedge clk);
    #1;
    check("shift_only_B", 8'h42);
    begin
      logic [7:0] unm [8];
      unm = '{8'h12, 8'hF0, 8'h00, 8'h58, 8'hE0, 8'h14, 8'h59, 8'h05};
      foreach (unm[j])
        for (int m = 0; m < 4; m++) begin
          step(0, 8'h1C, 0, 0);
          step(0, unm[j], m[1], m[0]);
          check($sformatf("unmapped_%02h_%0d", unm[j], m), 8'h00);
        end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
